// File: rtl/de0_nano_system_i2c_target.sv
// I2C target with an 8-byte register bank shared with an Avalon-MM slave.
// Bus pins are synchronized to clk; all protocol decisions use synchronized SCL/SDA edges.
module de0_nano_system_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_DATA  = 3'd3,
    S_WR_ACK   = 3'd4,
    S_RD_DATA  = 3'd5,
    S_RD_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rd_shift;
  logic [2:0]  r_ptr;
  logic        r_ptr_phase;
  logic        r_sda_oe;
  logic        r_wr_flag;
  logic [31:0] r_readdata;
  logic [7:0]  r_regs [8];

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_match, w_busy;
  logic w_sda_oe_nxt, w_cnt_clr, w_cnt_inc, w_shift_in, w_commit;
  logic w_rd_load, w_rd_shift, w_rd_ptr_inc, w_ptr_arm;
  logic w_avl_wr, w_i2c_wr, w_unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;   r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_in;   r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_match    = (r_shift[7:1] == TARGET_ADDR);
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_IGNORE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // START and STOP override every state; otherwise only SCL edges advance the FSM.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = w_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall) w_state_nxt = S_WR_DATA;
        S_RD_DATA:  if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (w_scl_rise && r_sda_s2) w_state_nxt = S_IGNORE;
          else if (w_scl_fall)        w_state_nxt = S_RD_DATA;
        end
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_sda_oe_nxt = r_sda_oe;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_shift_in   = 1'b0;
    w_commit     = 1'b0;
    w_rd_load    = 1'b0;
    w_rd_shift   = 1'b0;
    w_rd_ptr_inc = 1'b0;
    w_ptr_arm    = 1'b0;
    if (w_start || w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_in = 1'b1;
            w_cnt_inc  = 1'b1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_sda_oe_nxt = w_match;
            w_cnt_clr    = 1'b1;
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_clr = 1'b1;
            if (r_shift[0]) begin
              w_rd_load    = 1'b1;
              w_sda_oe_nxt = ~r_regs[r_ptr][7];
            end else begin
              w_ptr_arm    = 1'b1;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_in = 1'b1;
            w_cnt_inc  = 1'b1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_commit     = 1'b1;
            w_sda_oe_nxt = 1'b1;
            w_cnt_clr    = 1'b1;
          end
        end
        S_WR_ACK: if (w_scl_fall) w_sda_oe_nxt = 1'b0;
        S_RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_inc = 1'b1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_rd_ptr_inc = 1'b1;
              w_cnt_clr    = 1'b1;
            end else begin
              w_rd_shift   = 1'b1;
              w_sda_oe_nxt = ~r_rd_shift[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise && r_sda_s2) begin
            w_sda_oe_nxt = 1'b0;
          end else if (w_scl_fall) begin
            w_rd_load    = 1'b1;
            w_sda_oe_nxt = ~r_regs[r_ptr][7];
          end
        end
        default: w_sda_oe_nxt = 1'b0;
      endcase
    end
  end

  // Avalon: a transfer is one cycle with chipselect high; reads return data on the next cycle.
  assign w_avl_wr       = chipselect & ~write_n;
  assign w_i2c_wr       = w_commit & ~r_ptr_phase;
  assign w_unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rd_shift  <= 8'h00;
      r_ptr       <= 3'd0;
      r_ptr_phase <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wr_flag   <= 1'b0;
      r_readdata  <= 32'h0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else begin
      r_sda_oe <= w_sda_oe_nxt;
      if (w_cnt_clr)      r_bit_cnt <= 4'd0;
      else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_shift_in) r_shift <= {r_shift[6:0], r_sda_s2};
      if (w_rd_load)       r_rd_shift <= r_regs[r_ptr];
      else if (w_rd_shift) r_rd_shift <= {r_rd_shift[6:0], 1'b0};
      if (w_commit && r_ptr_phase)   r_ptr <= r_shift[2:0];
      else if (w_i2c_wr || w_rd_ptr_inc) r_ptr <= r_ptr + 3'd1;
      if (w_ptr_arm)     r_ptr_phase <= 1'b1;
      else if (w_commit) r_ptr_phase <= 1'b0;
      // Avalon write follows the I2C write so it wins on a same-register collision.
      if (w_i2c_wr)                  r_regs[r_ptr] <= r_shift;
      if (w_avl_wr && !address[3])   r_regs[address[2:0]] <= writedata[7:0];
      if (w_avl_wr && address == 4'd8) r_wr_flag <= 1'b0;
      if (w_i2c_wr)                  r_wr_flag <= 1'b1;
      if (chipselect && write_n) begin
        if (!address[3])           r_readdata <= {24'h0, r_regs[address[2:0]]};
        else if (address == 4'd8)  r_readdata <= {30'h0, r_wr_flag, w_busy};
        else                       r_readdata <= 32'h0;
      end
    end
  end

  assign readdata    = r_readdata;
  assign sda_oe      = r_sda_oe;
  assign o_dbg_state = r_state;

endmodule
